// File: rtl/multiciclo_memory.sv
// Unified instruction/data memory for the multicycle core: one access at a time,
// programmable wait states, byte/half/word lanes, load extension and misalignment flag.
module multiciclo_memory #(
   parameter int ADDR_WIDTH = 8,
   parameter int LATENCY    = 2
) (
   input  logic        clock_i,
   input  logic        reset_i,
   input  logic        read_memory_i,
   input  logic        write_memory_i,
   input  logic [31:0] address_i,
   input  logic [31:0] write_data_i,
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   output logic [31:0] read_data_o,
   output logic        ready_o,
   output logic        busy_o,
   output logic        misaligned_o,
   output logic [1:0]  state_o
);

   localparam int         DEPTH = 1 << ADDR_WIDTH;
   localparam logic [3:0] LAT   = 4'(LATENCY);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_RESPOND = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [3:0]            count_q, count_d;
   logic [ADDR_WIDTH+1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [1:0]            size_q, size_d;
   logic                  uns_q, uns_d;
   logic                  write_q, write_d;
   logic                  mis_q, mis_d;
   logic [31:0]           read_data_q, read_data_d;
   logic [31:0]           mem_q [DEPTH];

   logic                  commit;
   logic                  acc_mis;
   logic [1:0]            lane;
   logic [ADDR_WIDTH-1:0] word_idx;
   logic [31:0]           mem_word;
   logic [7:0]            ld_byte;
   logic [15:0]           ld_half;
   logic [31:0]           ld_value;
   logic [3:0]            byte_en;
   logic [31:0]           wr_lanes;
   logic                  unused_addr_bits;

   // Upper address bits wrap the memory and are intentionally dropped.
   assign unused_addr_bits = ^address_i[31:ADDR_WIDTH+2];

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      size_d  = size_q;
      uns_d   = uns_q;
      write_d = write_q;
      case (state_q)
         S_IDLE: begin
            if (read_memory_i || write_memory_i) begin
               addr_d  = address_i[ADDR_WIDTH+1:0];
               wdata_d = write_data_i;
               size_d  = size_i;
               uns_d   = unsigned_i;
               write_d = write_memory_i;
               count_d = LAT;
               state_d = (LAT == 4'd0) ? S_RESPOND : S_WAIT;
            end
         end
         S_WAIT: begin
            count_d = count_q - 4'd1;
            if (count_q <= 4'd1) state_d = S_RESPOND;
         end
         S_RESPOND: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // The access is resolved on the edge that enters RESPOND; the _d copies hold
   // the live inputs when a zero-latency request commits straight from IDLE.
   assign commit   = (state_d == S_RESPOND) && (state_q != S_RESPOND);
   assign lane     = addr_d[1:0];
   assign word_idx = addr_d[ADDR_WIDTH+1:2];
   assign acc_mis  = ((size_d == 2'b01) && addr_d[0]) || (size_d[1] && (lane != 2'b00));
   assign mem_word = mem_q[word_idx];
   assign ld_byte  = mem_word[{lane, 3'b000} +: 8];
   assign ld_half  = addr_d[1] ? mem_word[31:16] : mem_word[15:0];

   always_comb begin
      ld_value = mem_word;
      byte_en  = 4'b1111;
      wr_lanes = wdata_d;
      case (size_d)
         2'b00: begin
            ld_value = uns_d ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            byte_en  = 4'b0001 << lane;
            wr_lanes = {4{wdata_d[7:0]}};
         end
         2'b01: begin
            ld_value = uns_d ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
            byte_en  = addr_d[1] ? 4'b1100 : 4'b0011;
            wr_lanes = {2{wdata_d[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      read_data_d = read_data_q;
      mis_d       = mis_q;
      if (commit) begin
         mis_d = acc_mis;
         if (!write_d && !acc_mis) read_data_d = ld_value;
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q     <= S_IDLE;
         count_q     <= 4'd0;
         addr_q      <= '0;
         wdata_q     <= 32'd0;
         size_q      <= 2'd0;
         uns_q       <= 1'b0;
         write_q     <= 1'b0;
         mis_q       <= 1'b0;
         read_data_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
         write_q     <= write_d;
         mis_q       <= mis_d;
         read_data_q <= read_data_d;
      end
   end

   // Storage is never cleared; a reset on the commit edge still drops the store.
   always_ff @(posedge clock_i) begin
      if (!reset_i && commit && write_d && !acc_mis) begin
         for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) mem_q[word_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
         end
      end
   end

   assign read_data_o  = read_data_q;
   assign ready_o      = (state_q == S_RESPOND);
   assign busy_o       = (state_q != S_IDLE);
   assign misaligned_o = (state_q == S_RESPOND) && mis_q;
   assign state_o      = state_q;

endmodule

// File: tb/tb_multiciclo_memory.sv
// Bench for multiciclo_memory: one LATENCY=2 and one LATENCY=0 instance, each
// scored against a byte-array memory model.
module tb_multiciclo_memory;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rd = 1'b0;
   logic        wr = 1'b0;
   logic [31:0] addr = 32'd0;
   logic [31:0] wdata = 32'd0;
   logic [1:0]  size = 2'd0;
   logic        uns = 1'b0;
   logic        sel = 1'b0;

   logic [31:0] rdata [2];
   logic        ready [2];
   logic        busy  [2];
   logic        mis   [2];
   logic [1:0]  st    [2];

   int          lat [2] = '{2, 0};
   logic [7:0]  mb [2][1024];
   logic [31:0] exp_rd [2];
   logic [31:0] exp_q [$];
   int          n_checks = 0;
   int          n_pass = 0;

   always #5 clk = ~clk;

   multiciclo_memory #(.ADDR_WIDTH(8), .LATENCY(2)) u_dut_l2 (
      .clock_i(clk), .reset_i(rst),
      .read_memory_i(rd & ~sel), .write_memory_i(wr & ~sel),
      .address_i(addr), .write_data_i(wdata), .size_i(size), .unsigned_i(uns),
      .read_data_o(rdata[0]), .ready_o(ready[0]), .busy_o(busy[0]),
      .misaligned_o(mis[0]), .state_o(st[0])
   );

   multiciclo_memory #(.ADDR_WIDTH(8), .LATENCY(0)) u_dut_l0 (
      .clock_i(clk), .reset_i(rst),
      .read_memory_i(rd & sel), .write_memory_i(wr & sel),
      .address_i(addr), .write_data_i(wdata), .size_i(size), .unsigned_i(uns),
      .read_data_o(rdata[1]), .ready_o(ready[1]), .busy_o(busy[1]),
      .misaligned_o(mis[1]), .state_o(st[1])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
   endtask

   function automatic bit model_mis(input logic [31:0] a, input logic [1:0] sz);
      if (sz == 2'b00) return 1'b0;
      if (sz == 2'b01) return a[0];
      return a[1:0] != 2'b00;
   endfunction

   // Updates the byte model and queues the load data expected at completion.
   task automatic model_access(input int d, input bit is_wr, input logic [31:0] a,
                               input logic [31:0] dat, input logic [1:0] sz, input bit u);
      int          nb;
      int          base;
      logic [31:0] v;
      nb   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      base = int'(a % 1024);
      if (!model_mis(a, sz)) begin
         if (is_wr) begin
            for (int k = 0; k < nb; k++) mb[d][base + k] = dat[8*k +: 8];
         end else begin
            v = 32'd0;
            for (int k = 0; k < nb; k++) v = v | (32'(mb[d][base + k]) << (8*k));
            if (!u && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
            exp_rd[d] = v;
         end
      end
      exp_q.push_back(exp_rd[d]);
   endtask

   task automatic access(input int d, input bit is_wr, input bit both, input logic [31:0] a,
                         input logic [31:0] dat, input logic [1:0] sz, input bit u, input bit noise);
      int cyc;
      bit seen;
      model_access(d, is_wr || both, a, dat, sz, u);
      @(negedge clk);
      check("idle_busy", 32'(busy[d]), 32'd0);
      check("idle_ready", 32'(ready[d]), 32'd0);
      sel   = d[0];
      addr  = a;
      wdata = dat;
      size  = sz;
      uns   = u;
      wr    = is_wr || both;
      rd    = !is_wr || both;
      @(posedge clk);
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (ready[d]) begin
            seen = 1'b1;
            rd = 1'b0;
            wr = 1'b0;
         end else begin
            check("busy_wait", 32'(busy[d]), 32'd1);
            rd = noise ? 1'($urandom) : 1'b0;
            wr = noise ? 1'($urandom) : 1'b0;
            if (noise) begin
               addr  = $urandom;
               wdata = $urandom;
               size  = 2'($urandom_range(0, 3));
            end
         end
      end
      rd = 1'b0;
      wr = 1'b0;
      check("latency", 32'(cyc), 32'(lat[d] + 1));
      check("busy_respond", 32'(busy[d]), 32'd1);
      check("misaligned", 32'(mis[d]), 32'(model_mis(a, sz)));
      check("read_data", rdata[d], exp_q.pop_front());
   endtask

   task automatic check_reset_outputs(input string tag);
      for (int d = 0; d < 2; d++) begin
         check({tag, "_rdata"}, rdata[d], 32'd0);
         check({tag, "_ready"}, 32'(ready[d]), 32'd0);
         check({tag, "_busy"}, 32'(busy[d]), 32'd0);
         check({tag, "_mis"}, 32'(mis[d]), 32'd0);
      end
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_rd[0] = 32'd0;
      exp_rd[1] = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset_init");
      rst = 1'b0;

      for (int d = 0; d < 2; d++)
         for (int w = 0; w < 256; w++) access(d, 1, 0, 32'(w * 4), $urandom, 2'b10, 0, 0);

      // Abort a pending store with reset while it is waiting.
      access(0, 1, 0, 32'h10, 32'hCAFE_F00D, 2'b10, 0, 0);
      @(negedge clk);
      sel = 1'b0; addr = 32'h10; wdata = 32'hDEAD_BEEF; size = 2'b10; wr = 1'b1;
      @(posedge clk);
      @(negedge clk);
      wr  = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset_mid");
      @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset_mid2");
      rst = 1'b0;
      exp_rd[0] = 32'd0;
      exp_rd[1] = 32'd0;
      access(0, 0, 0, 32'h10, 32'd0, 2'b10, 0, 0);
      check("abort_const", rdata[0], 32'hCAFE_F00D);

      access(0, 1, 0, 32'h20, 32'h1234_5678, 2'b10, 0, 0);
      access(0, 0, 0, 32'h20, 32'd0, 2'b10, 0, 0);
      check("word_const", rdata[0], 32'h1234_5678);

      access(0, 1, 0, 32'h40, 32'h0, 2'b10, 0, 0);
      access(0, 1, 0, 32'h41, 32'h80, 2'b00, 0, 0);
      access(0, 1, 0, 32'h42, 32'hBEEF, 2'b01, 0, 0);
      access(0, 0, 0, 32'h40, 32'd0, 2'b10, 0, 0);
      check("lane_word_const", rdata[0], 32'hBEEF_8000);
      access(0, 0, 0, 32'h41, 32'd0, 2'b00, 0, 0);
      check("lane_sbyte_const", rdata[0], 32'hFFFF_FF80);
      access(0, 0, 0, 32'h41, 32'd0, 2'b00, 1, 0);
      check("lane_ubyte_const", rdata[0], 32'h0000_0080);
      access(0, 0, 0, 32'h42, 32'd0, 2'b01, 0, 0);
      check("lane_shalf_const", rdata[0], 32'hFFFF_BEEF);

      access(0, 1, 0, 32'h22, 32'hAAAA_AAAA, 2'b10, 0, 0);
      access(0, 0, 0, 32'h20, 32'd0, 2'b10, 0, 0);
      check("mis_word_const", rdata[0], 32'h1234_5678);
      access(0, 0, 0, 32'h43, 32'd0, 2'b01, 0, 0);
      check("mis_half_const", rdata[0], 32'h1234_5678);

      access(0, 0, 1, 32'h30, 32'h55, 2'b10, 0, 0);
      access(0, 0, 0, 32'h30, 32'd0, 2'b10, 0, 0);
      check("both_const", rdata[0], 32'h55);
      access(0, 1, 0, 32'h34, 32'h0BAD_F00D, 2'b10, 0, 1);
      access(0, 0, 0, 32'h34, 32'd0, 2'b10, 0, 1);
      access(0, 1, 0, 32'h430, 32'h7777_1111, 2'b10, 0, 0);
      access(0, 0, 0, 32'h30, 32'd0, 2'b10, 0, 0);
      check("alias_const", rdata[0], 32'h7777_1111);

      access(1, 1, 0, 32'h80, 32'h0102_0304, 2'b10, 0, 0);
      access(1, 0, 0, 32'h80, 32'd0, 2'b10, 0, 0);
      check("lat0_const", rdata[1], 32'h0102_0304);
      access(1, 0, 0, 32'h83, 32'd0, 2'b00, 1, 0);
      access(1, 0, 0, 32'h82, 32'd0, 2'b01, 0, 0);

      for (int i = 0; i < 400; i++) begin
         access($urandom_range(0, 1), 1'($urandom), ($urandom_range(0, 7) == 0),
                $urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom),
                1'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
